// File: rtl/mem_controller_rr.sv
// mem_controller_rr: round-robin arbiter that maps NUM_CONSUMERS load/store
// requesters onto NUM_CHANNELS independent memory channels. Each channel runs
// a small FSM; all outputs are registered next-state values.
module mem_controller_rr #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready,
  output logic [NUM_CHANNELS-1:0]  channel_busy
);

  localparam int PW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int PW1 = PW + 1;

  typedef logic [PW-1:0] cidx_t;
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t                   state     [NUM_CHANNELS];
  state_t                   state_nxt [NUM_CHANNELS];
  cidx_t                    owner     [NUM_CHANNELS];
  cidx_t                    owner_nxt [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] serving, serving_nxt, claimed;
  cidx_t                    rr_ptr, rr_ptr_nxt, cand, pick;
  logic                     found, hit;

  logic [NUM_CONSUMERS-1:0] rd_ready_nxt, wr_ready_nxt;
  logic [DATA_BITS-1:0]     rd_data_nxt [NUM_CONSUMERS];
  logic [NUM_CHANNELS-1:0]  m_rv_nxt, m_wv_nxt, busy_nxt;
  logic [ADDR_BITS-1:0]     m_ra_nxt [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     m_wa_nxt [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     m_wd_nxt [NUM_CHANNELS];

  // (base + k) mod NUM_CONSUMERS; base < NUM_CONSUMERS and k <= NUM_CONSUMERS,
  // so one conditional subtraction covers the wrap.
  function automatic cidx_t cons_at(input cidx_t base, input int k);
    logic [PW1-1:0] s;
    s = {1'b0, base} + PW1'(k);
    if (s >= PW1'(NUM_CONSUMERS)) begin
      s = s - PW1'(NUM_CONSUMERS);
    end else begin
      s = s;
    end
    return s[PW-1:0];
  endfunction

  // Arbitration and per-channel FSM next state; channels are visited in index
  // order so a claim by a lower channel hides that consumer from higher ones.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    serving_nxt  = serving;
    claimed      = serving;
    rr_ptr_nxt   = rr_ptr;
    rd_ready_nxt = consumer_read_ready;
    wr_ready_nxt = consumer_write_ready;
    rd_data_nxt  = consumer_read_data;
    m_rv_nxt     = mem_read_valid;
    m_wv_nxt     = mem_write_valid;
    m_ra_nxt     = mem_read_address;
    m_wa_nxt     = mem_write_address;
    m_wd_nxt     = mem_write_data;
    busy_nxt     = '0;
    found        = 1'b0;
    hit          = 1'b0;
    cand         = '0;
    pick         = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      case (state[i])
        IDLE: begin
          found = 1'b0;
          pick  = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand  = cons_at(rr_ptr, k);
            hit   = !found && !claimed[cand] &&
                    (consumer_read_valid[cand] || (WRITE_ENABLE && consumer_write_valid[cand]));
            pick  = hit ? cand : pick;
            found = found | hit;
          end
          if (found) begin
            claimed[pick]     = 1'b1;
            serving_nxt[pick] = 1'b1;
            owner_nxt[i]      = pick;
            rr_ptr_nxt        = cons_at(pick, 1);
            // A simultaneous read and write from one consumer: read goes first.
            if (consumer_read_valid[pick]) begin
              m_rv_nxt[i]  = 1'b1;
              m_ra_nxt[i]  = consumer_read_address[pick];
              state_nxt[i] = READ_WAITING;
            end else begin
              m_wv_nxt[i]  = 1'b1;
              m_wa_nxt[i]  = consumer_write_address[pick];
              m_wd_nxt[i]  = consumer_write_data[pick];
              state_nxt[i] = WRITE_WAITING;
            end
          end else begin
            state_nxt[i] = IDLE;
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[i]) begin
            m_rv_nxt[i]              = 1'b0;
            rd_ready_nxt[owner[i]]   = 1'b1;
            rd_data_nxt[owner[i]]    = mem_read_data[i];
            state_nxt[i]             = READ_RELAYING;
          end else begin
            state_nxt[i] = READ_WAITING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[i]) begin
            m_wv_nxt[i]            = 1'b0;
            wr_ready_nxt[owner[i]] = 1'b1;
            state_nxt[i]           = WRITE_RELAYING;
          end else begin
            state_nxt[i] = WRITE_WAITING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[owner[i]]) begin
            rd_ready_nxt[owner[i]] = 1'b0;
            serving_nxt[owner[i]]  = 1'b0;
            state_nxt[i]           = IDLE;
          end else begin
            state_nxt[i] = READ_RELAYING;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[owner[i]]) begin
            wr_ready_nxt[owner[i]] = 1'b0;
            serving_nxt[owner[i]]  = 1'b0;
            state_nxt[i]           = IDLE;
          end else begin
            state_nxt[i] = WRITE_RELAYING;
          end
        end
        default: begin
          state_nxt[i] = IDLE;
        end
      endcase
      busy_nxt[i] = (state_nxt[i] != IDLE);
    end
  end

  // State, pointer and registered outputs; a read-only build pins write handshakes low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]             <= IDLE;
        owner[i]             <= '0;
        mem_read_address[i]  <= '0;
        mem_write_address[i] <= '0;
        mem_write_data[i]    <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        consumer_read_data[c] <= '0;
      end
      serving              <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_write_valid      <= '0;
      channel_busy         <= '0;
    end else begin
      state                <= state_nxt;
      owner                <= owner_nxt;
      mem_read_address     <= m_ra_nxt;
      mem_write_address    <= m_wa_nxt;
      mem_write_data       <= m_wd_nxt;
      consumer_read_data   <= rd_data_nxt;
      serving              <= serving_nxt;
      rr_ptr               <= rr_ptr_nxt;
      consumer_read_ready  <= rd_ready_nxt;
      consumer_write_ready <= WRITE_ENABLE ? wr_ready_nxt : '0;
      mem_read_valid       <= m_rv_nxt;
      mem_write_valid      <= WRITE_ENABLE ? m_wv_nxt : '0;
      channel_busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_controller_rr.sv
// Bench for mem_controller_rr: a 2-channel read/write instance and a
// 1-channel read-only instance, checked against a response scoreboard.
module tb_mem_controller_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 4 consumers, 2 channels, writes enabled
  logic [3:0]  a_crv, a_cwv, a_crr, a_cwr;
  logic [7:0]  a_cra [4];
  logic [7:0]  a_cwa [4];
  logic [15:0] a_cwd [4];
  logic [15:0] a_crd [4];
  logic [1:0]  a_mrv, a_mrr, a_mwv, a_mwr, a_busy;
  logic [7:0]  a_mra [2];
  logic [7:0]  a_mwa [2];
  logic [15:0] a_mrd [2];
  logic [15:0] a_mwd [2];

  // Instance B: 4 consumers, 1 channel, read-only
  logic [3:0]  b_crv, b_cwv, b_crr, b_cwr;
  logic [7:0]  b_cra [4];
  logic [7:0]  b_cwa [4];
  logic [15:0] b_cwd [4];
  logic [15:0] b_crd [4];
  logic [0:0]  b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
  logic [7:0]  b_mra [1];
  logic [7:0]  b_mwa [1];
  logic [15:0] b_mrd [1];
  logic [15:0] b_mwd [1];

  mem_controller_rr #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4),
                      .NUM_CHANNELS(2), .WRITE_ENABLE(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
    .channel_busy(a_busy)
  );

  mem_controller_rr #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4),
                      .NUM_CHANNELS(1), .WRITE_ENABLE(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
    .channel_busy(b_busy)
  );

  typedef struct {
    int          cons;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  grant_q [$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] mem_model(input logic [7:0] a);
    return {~a, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one expected read completion for instance A and compare it.
  task automatic pop_read(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      if (a_crr[e.cons] !== 1'b1 || a_crd[e.cons] !== e.data) begin
        errors++;
        $display("FAIL %s: consumer %0d ready=%b data=%h, expected ready=1 data=%h",
                 name, e.cons, a_crr[e.cons], a_crd[e.cons], e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_crv = '0; a_cwv = '0; a_mrr = '0; a_mwr = '0;
    b_crv = '0; b_cwv = '0; b_mrr = '0; b_mwr = '0;
    for (int c = 0; c < 4; c++) begin
      a_cra[c] = '0; a_cwa[c] = '0; a_cwd[c] = '0;
      b_cra[c] = '0; b_cwa[c] = '0; b_cwd[c] = '0;
    end
    for (int i = 0; i < 2; i++) a_mrd[i] = '0;
    b_mrd[0] = '0;
    tick(); tick();
    checks++;
    if ({a_mrv, a_mwv, a_busy} !== 6'b0) begin
      errors++; $display("FAIL reset_chan: mrv=%b mwv=%b busy=%b, expected all 0", a_mrv, a_mwv, a_busy);
    end
    checks++;
    if ({a_crr, a_cwr} !== 8'b0) begin
      errors++; $display("FAIL reset_cons: crr=%b cwr=%b, expected 0", a_crr, a_cwr);
    end
    checks++;
    if (a_crd[2] !== 16'h0 || a_mra[0] !== 8'h0 || a_mwd[1] !== 16'h0) begin
      errors++; $display("FAIL reset_data: crd2=%h mra0=%h mwd1=%h, expected 0", a_crd[2], a_mra[0], a_mwd[1]);
    end
    checks++;
    if ({b_mrv, b_busy, b_crr} !== 6'b0) begin
      errors++; $display("FAIL reset_b: mrv=%b busy=%b crr=%b, expected 0", b_mrv, b_busy, b_crr);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    a_crv[2] = 1'b1; a_cra[2] = 8'h3C;
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (a_mrv !== 2'b01 || a_mra[0] !== 8'h3C || a_busy !== 2'b01 || a_crr !== 4'b0) begin
        errors++;
        $display("FAIL read_wait[%0d]: mrv=%b addr=%h busy=%b crr=%b, expected 01 3c 01 0000",
                 j, a_mrv, a_mra[0], a_busy, a_crr);
      end
      if (j < 2) tick();
    end
    a_mrr[0] = 1'b1; a_mrd[0] = 16'hBEEF;
    exp_q.push_back('{cons: 2, data: 16'hBEEF});
    tick();
    pop_read("read_done");
    checks++;
    if (a_crr !== 4'b0100 || a_mrv !== 2'b00 || a_mra[0] !== 8'h3C || a_busy !== 2'b01) begin
      errors++;
      $display("FAIL read_relay: crr=%b mrv=%b addr=%h busy=%b, expected 0100 00 3c 01",
               a_crr, a_mrv, a_mra[0], a_busy);
    end
    a_mrr[0] = 1'b0; a_crv[2] = 1'b0;
    tick();
    checks++;
    if (a_crr !== 4'b0 || a_busy !== 2'b00 || a_crd[2] !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_release: crr=%b busy=%b crd2=%h, expected 0000 00 beef", a_crr, a_busy, a_crd[2]);
    end
  endtask

  task automatic test_dual_grant();
    a_crv = 4'b0011; a_cra[0] = 8'h20; a_cra[1] = 8'h21;
    tick();
    checks++;
    if (a_mrv !== 2'b11 || a_mra[0] !== 8'h20 || a_mra[1] !== 8'h21 || a_busy !== 2'b11) begin
      errors++;
      $display("FAIL dual_grant: mrv=%b a0=%h a1=%h busy=%b, expected 11 20 21 11",
               a_mrv, a_mra[0], a_mra[1], a_busy);
    end
    a_mrr = 2'b11; a_mrd[0] = mem_model(8'h20); a_mrd[1] = mem_model(8'h21);
    exp_q.push_back('{cons: 0, data: mem_model(8'h20)});
    exp_q.push_back('{cons: 1, data: mem_model(8'h21)});
    tick();
    checks++;
    if (a_crr !== 4'b0011) begin
      errors++; $display("FAIL dual_ready: crr=%b, expected 0011", a_crr);
    end
    pop_read("dual_data0");
    pop_read("dual_data1");
    a_mrr = 2'b00; a_crv = 4'b0000;
    tick();
    // Pointer now sits at 2: with all four requesting, channels take 2 and 3.
    a_crv = 4'b1111;
    for (int c = 0; c < 4; c++) a_cra[c] = 8'h30 + 8'(c);
    tick();
    checks++;
    if (a_mra[0] !== 8'h32 || a_mra[1] !== 8'h33 || a_mrv !== 2'b11) begin
      errors++;
      $display("FAIL rr_ptr_probe: a0=%h a1=%h mrv=%b, expected 32 33 11", a_mra[0], a_mra[1], a_mrv);
    end
    a_mrr = 2'b11; a_mrd[0] = mem_model(8'h32); a_mrd[1] = mem_model(8'h33);
    exp_q.push_back('{cons: 2, data: mem_model(8'h32)});
    exp_q.push_back('{cons: 3, data: mem_model(8'h33)});
    tick();
    checks++;
    if (a_crr !== 4'b1100) begin
      errors++; $display("FAIL probe_ready: crr=%b, expected 1100", a_crr);
    end
    pop_read("probe_data2");
    pop_read("probe_data3");
    a_mrr = 2'b00; a_crv = 4'b0000;
    tick();
    checks++;
    if (a_crr !== 4'b0 || a_busy !== 2'b00) begin
      errors++; $display("FAIL probe_release: crr=%b busy=%b, expected 0000 00", a_crr, a_busy);
    end
  endtask

  task automatic test_read_before_write();
    a_crv[1] = 1'b1; a_cra[1] = 8'h44;
    a_cwv[1] = 1'b1; a_cwa[1] = 8'h55; a_cwd[1] = 16'h1234;
    tick();
    checks++;
    if (a_mrv !== 2'b01 || a_mwv !== 2'b00 || a_mra[0] !== 8'h44) begin
      errors++;
      $display("FAIL rw_read_first: mrv=%b mwv=%b a0=%h, expected 01 00 44", a_mrv, a_mwv, a_mra[0]);
    end
    a_mrr[0] = 1'b1; a_mrd[0] = mem_model(8'h44);
    exp_q.push_back('{cons: 1, data: mem_model(8'h44)});
    tick();
    pop_read("rw_read_data");
    checks++;
    if (a_cwr !== 4'b0 || a_mwv !== 2'b00) begin
      errors++; $display("FAIL rw_no_write_yet: cwr=%b mwv=%b, expected 0000 00", a_cwr, a_mwv);
    end
    a_mrr[0] = 1'b0; a_crv[1] = 1'b0;
    tick();
    checks++;
    if (a_crr !== 4'b0 || a_mwv !== 2'b00) begin
      errors++; $display("FAIL rw_release: crr=%b mwv=%b, expected 0000 00", a_crr, a_mwv);
    end
    tick();
    checks++;
    if (a_mwv !== 2'b01 || a_mwa[0] !== 8'h55 || a_mwd[0] !== 16'h1234 || a_busy !== 2'b01) begin
      errors++;
      $display("FAIL rw_write_grant: mwv=%b wa=%h wd=%h busy=%b, expected 01 55 1234 01",
               a_mwv, a_mwa[0], a_mwd[0], a_busy);
    end
    a_mwr[0] = 1'b1;
    tick();
    checks++;
    if (a_cwr !== 4'b0010 || a_mwv !== 2'b00) begin
      errors++; $display("FAIL rw_write_done: cwr=%b mwv=%b, expected 0010 00", a_cwr, a_mwv);
    end
    a_mwr[0] = 1'b0; a_cwv[1] = 1'b0;
    tick();
    checks++;
    if (a_cwr !== 4'b0 || a_busy !== 2'b00) begin
      errors++; $display("FAIL rw_write_release: cwr=%b busy=%b, expected 0000 00", a_cwr, a_busy);
    end
  endtask

  task automatic test_reset_mid();
    a_crv[3] = 1'b1; a_cra[3] = 8'h66;
    tick();
    checks++;
    if (a_mrv !== 2'b01 || a_mra[0] !== 8'h66) begin
      errors++; $display("FAIL mid_grant: mrv=%b a0=%h, expected 01 66", a_mrv, a_mra[0]);
    end
    reset = 1'b1; a_mrr[0] = 1'b1; a_mrd[0] = 16'h1111;
    tick();
    checks++;
    if (a_mrv !== 2'b00 || a_crr !== 4'b0 || a_busy !== 2'b00) begin
      errors++; $display("FAIL mid_reset: mrv=%b crr=%b busy=%b, expected 00 0000 00", a_mrv, a_crr, a_busy);
    end
    reset = 1'b0; a_crv = 4'b0000; a_mrr = 2'b00;
    tick();
    checks++;
    if (a_crr !== 4'b0 || a_mrv !== 2'b00 || a_crd[3] !== 16'h0) begin
      errors++; $display("FAIL mid_after: crr=%b mrv=%b crd3=%h, expected 0000 00 0000", a_crr, a_mrv, a_crd[3]);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    grant_q.push_back(8'h70); grant_q.push_back(8'h71); grant_q.push_back(8'h72);
    grant_q.push_back(8'h73); grant_q.push_back(8'h70);
    for (int c = 0; c < 4; c++) b_cra[c] = 8'h70 + 8'(c);
    b_crv = 4'b1111; b_mrr = 1'b1;
    for (int cyc = 0; cyc < 40 && grant_q.size() > 0; cyc++) begin
      tick();
      if (b_mrv[0]) begin
        want = grant_q.pop_front();
        checks++;
        if (b_mra[0] !== want) begin
          errors++; $display("FAIL rr_order: granted addr=%h, expected %h", b_mra[0], want);
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (b_crr[c]) begin
          checks++;
          if (b_crd[c] !== mem_model(8'h70 + 8'(c))) begin
            errors++; $display("FAIL rr_data[%0d]: got %h, expected %h", c, b_crd[c], mem_model(8'h70 + 8'(c)));
          end
        end
        b_crv[c] = ~b_crr[c];
      end
      b_mrd[0] = mem_model(b_mra[0]);
    end
    checks++;
    if (grant_q.size() != 0) begin
      errors++; $display("FAIL rr_timeout: %0d grants outstanding, expected 0", grant_q.size());
    end
    b_crv = 4'b0000;
    tick(); tick(); tick();
    b_mrr = 1'b0;
    tick();
    checks++;
    if (b_busy !== 1'b0 || b_crr !== 4'b0) begin
      errors++; $display("FAIL rr_drain: busy=%b crr=%b, expected 0 0000", b_busy, b_crr);
    end
  endtask

  task automatic test_write_disabled();
    b_cwv = 4'b1111; b_mwr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b_cwa[c] = 8'h90 + 8'(c); b_cwd[c] = 16'hC000 + 16'(c);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      checks++;
      if (b_mwv !== 1'b0 || b_cwr !== 4'b0 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL wr_disabled[%0d]: mwv=%b cwr=%b busy=%b, expected 0 0000 0", cyc, b_mwv, b_cwr, b_busy);
      end
    end
    b_cwv = 4'b0000; b_mwr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_dual_grant();
    test_read_before_write();
    test_reset_mid();
    test_round_robin();
    test_write_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_controller_rr.md
Name: mem_controller_rr

Overview:
Multi-channel memory request controller that arbitrates NUM_CONSUMERS load/store requesters onto NUM_CHANNELS independent memory channels. It is the parametrised successor to the fixed-priority controller. It adds round-robin fairness, guarantees that one consumer is never claimed by two channels in the same cycle, and reports per-channel busy status. It sits between the per-core LSUs (or the instruction fetchers) and the external memory interface.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 16, data width.
- NUM_CONSUMERS, 4, number of requesters; must be ≥1.
- NUM_CHANNELS, 2, number of memory channels; must be ≥1 and ≤NUM_CONSUMERS.
- WRITE_ENABLE, 1, 0 builds a read-only controller.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  [NUM_CONSUMERS]  read request per consumer.
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  read address.
- consumer_read_ready  out  [NUM_CONSUMERS]  read-complete flag.
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned read data.
- consumer_write_valid  in  [NUM_CONSUMERS]  write request per consumer.
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address.
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  write-complete flag.
- mem_read_valid  out  [NUM_CHANNELS]  channel read request.
- mem_read_address  out  ADDR_BITS x NUM_CHANNELS  read address.
- mem_read_ready  in  [NUM_CHANNELS]  memory read done.
- mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data.
- mem_write_valid  out  [NUM_CHANNELS]  channel write request.
- mem_write_address  out  ADDR_BITS x NUM_CHANNELS  write address.
- mem_write_data  out  DATA_BITS x NUM_CHANNELS  write data.
- mem_write_ready  in  [NUM_CHANNELS]  memory write done.
- channel_busy  out  [NUM_CHANNELS]  channel not IDLE.

Behaviour:
- All outputs are registered.
- Reset clears every output to 0, all channels to IDLE, every serving flag, and rr_ptr. rr_ptr is max(1,$clog2(NUM_CONSUMERS)) bits wide.
- Reset mid-transaction abandons any in-flight memory access. No completion is reported for it.
- Each channel runs its own state machine: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Arbitration happens in IDLE. Within one cycle, IDLE channels are evaluated in index order 0..NUM_CHANNELS-1.
  - Each channel scans consumers (rr_ptr+k) mod NUM_CONSUMERS for k = 0..NUM_CONSUMERS-1.
  - It takes the first eligible consumer. Eligible means (read_valid, or write_valid with WRITE_ENABLE=1), the consumer is not being served, and no lower-index channel claimed it this cycle.
- Claims made within a cycle are blocking. Two channels never get the same consumer.
- If a consumer has read_valid and write_valid both high, the read wins. The write is served in a later grant.
- Read grant, edge T:
  - mem_read_valid=1 and mem_read_address latched from the consumer.
  - Serving flag set.
  - Channel moves to READ_WAITING.
- Write grant, edge T:
  - mem_write_valid=1, with address and data latched from the consumer.
  - Serving flag set.
  - Channel moves to WRITE_WAITING.
- rr_ptr: if at least one grant occurs in a cycle, rr_ptr ← (highest-index channel's granted consumer + 1) mod NUM_CONSUMERS. Otherwise it is unchanged.
- WAITING: on an edge with mem_*_ready[i]=1:
  - mem_*_valid[i] ← 0.
  - consumer_*_ready[c] ← 1.
  - For reads, consumer_read_data[c] ← mem_read_data[i].
  - Channel moves to RELAYING.
  - Address and data outputs hold their values. A ready with no valid outstanding is ignored.
- RELAYING: on an edge where the consumer's matching valid is 0:
  - consumer_*_ready[c] ← 0 and the serving flag clears.
  - Channel moves to IDLE.
  - The consumer can be re-granted one cycle later at the earliest.
- consumer_read_data[c] holds its value until the next read completes for that consumer.
- channel_busy[i] is registered and equals (next state ≠ IDLE). It is 1 from the grant edge through the RELAYING exit edge.
- WRITE_ENABLE=0: write_valid is ignored, and consumer_write_ready and mem_write_valid are held at 0.
- Minimum read round trip with mem_read_ready already high: request seen at edge T, grant at T, ready to consumer at T+1.
- Channels progress independently. Simultaneous ready events on different channels are all handled in the same edge.

Test Plan:
- Reset → all outputs 0 and channel_busy=00. Assert reset mid-READ_WAITING → mem_read_valid drops next edge and no consumer_read_ready is asserted.
- Consumer 2 reads address 0x3C, memory answers 0xBEEF after 3 cycles → mem_read_valid[0]=1 and address 0x3C for 3 cycles, then consumer_read_ready[2]=1 with data 0xBEEF. Drop valid → ready 0 next edge.
- Consumers 0 and 1 both request reads in the same cycle with 2 channels → channel0 serves 0 and channel1 serves 1 on the same edge. No duplicate claims; rr_ptr=2.
- NUM_CHANNELS=1, all 4 consumers request reads continuously with immediate ready → grant order 0,1,2,3,0.
- Consumer 1 has read_valid and write_valid both high → read issued first. The write is issued only after the read completes and read_valid drops.
- WRITE_ENABLE=0 with write_valid=1111 for 20 cycles → mem_write_valid stays 0, consumer_write_ready stays 0, channel_busy stays 0.
